write_pointer_controller: RTL and testbench
===========================================

// Module: write_pointer_controller
// PURPOSE
//  Write-domain pointer/flag generator for the async FIFO, successor to the basic write handler.
//  Synchronises the read-domain gray pointer internally and produces address, gray pointer,
//  full, almost-full and fill level. Lives in the write clock domain beside the dual-port RAM.
// PARAMETERS
//  ADDRESS_SIZE        5  RAM address width; DEPTH = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits
//  SYNC_STAGES         2  flops in read-pointer synchroniser; legal range >= 2
//  ALMOST_FULL_MARGIN  4  almost-full when level >= DEPTH-ALMOST_FULL_MARGIN; legal 1..DEPTH-1
// PORTS
//  write_clock        in   1               write-domain clock, rising edge
//  reset              in   1               asynchronous, active-high; clears all state
//  write_enable       in   1               write request for this cycle
//  read_gray_pointer  in   ADDRESS_SIZE+1  read pointer, gray, from read domain (unsynchronised)
//  write_accept       out  1               comb: write_enable && !write_full; qualifies RAM write
//  write_address      out  ADDRESS_SIZE    RAM write address = binary[ADDRESS_SIZE-1:0]
//  write_pointer      out  ADDRESS_SIZE+1  registered gray write pointer, to read domain
//  write_full         out  1               registered full flag
//  write_almost_full  out  1               registered almost-full flag
//  write_level        out  ADDRESS_SIZE+1  registered fill level, 0..DEPTH
//  write_overflow     out  1               sticky overflow flag (only with WRITE_OVERFLOW_FLAG_EN)
// BEHAVIOUR
//  - Reset: sync chain, binary, write_pointer, write_full, write_almost_full, write_level,
//    write_overflow all 0. Applies immediately, no clock needed; release is on a clock edge.
//  - Sync: read_gray_pointer passes through SYNC_STAGES flops; last stage converts gray->binary (rbin).
//  - binary_next = binary + write_accept (mod 2**(ADDRESS_SIZE+1)); gray_next = binary_next ^ (binary_next>>1).
//  - Each edge: binary<=binary_next; write_pointer<=gray_next.
//  - level_next = binary_next - rbin (mod 2**(ADDRESS_SIZE+1)); write_level<=level_next.
//  - write_full<=(binary_next=={~rbin[MSB],rbin[MSB-1:0]}); equivalently level_next==DEPTH.
//  - write_almost_full<=(level_next >= DEPTH-ALMOST_FULL_MARGIN); write_full implies almost_full.
//  - Write latency: an accepted write updates address/pointer/level/full at the same edge.
//  - Read latency: a read_gray_pointer change reaches full/level after exactly SYNC_STAGES+1 edges.
//  - Flags are pessimistic: a stale rbin can only overstate level, never understate it.
//  - Write while full: ignored; write_accept=0; binary, pointer and level hold.
//  - Wrap-around: binary rolls 2**(ADDRESS_SIZE+1)-1 -> 0; MSB inversion keeps full/empty
//    distinct; the gray pointer changes one bit per increment, including across the wrap.
//  - Reset mid-operation: any in-flight state is discarded; the FIFO restarts empty.
//    The read domain must be reset in the same window.
// CONFIGURATION
//  WRITE_OVERFLOW_FLAG_EN defined: write_overflow<=1 on any edge with write_enable && write_full;
//    it stays 1 until reset.
//  Not defined: write_overflow is tied to 0 and no flop is inferred; all other behaviour is identical.
// TESTING (ADDRESS_SIZE=3, DEPTH=8, SYNC_STAGES=2, ALMOST_FULL_MARGIN=2)
//  1 Assert reset with no clock -> all outputs 0 immediately; write_address=3'd0.
//  2 read_gray_pointer=0, 8 back-to-back writes -> level 1..8. almost_full=1 after the 6th edge.
//    full=1 after the 8th edge. write_pointer=4'b1100. write_address=3'd0.
//  3 Write held while full for 3 cycles -> write_accept=0; write_pointer/address/level unchanged.
//    With the macro: write_overflow=1 and still 1 after full clears. Without it: write_overflow=0.
//  4 Full, then read_gray_pointer=4'b0010 (bin 3) -> full=0 and level=5 exactly 3 edges later;
//    almost_full=0 (5 < 6).
//  5 Wrap: 16 writes interleaved with reads -> write_pointer 4'b1000 -> 4'b0000 at bin 15->0,
//    one bit changing per step; full never asserted while level < 8.
//  6 Reset asserted mid-burst at level 5 -> outputs 0 at once.
//    After release and 1 write: level=1, write_pointer=4'b0001.

Source files
------------

// File: rtl/write_pointer_controller.sv
// Write-domain pointer and flag generator for an async FIFO: synchronises the read gray pointer,
// advances the write pointer and derives full/almost-full/level. Option macro: WRITE_OVERFLOW_FLAG_EN.
module write_pointer_controller #(
    parameter int ADDRESS_SIZE       = 5,
    parameter int SYNC_STAGES        = 2,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                    write_clock_i,
    input  logic                    reset_i,
    input  logic                    write_enable_i,
    input  logic [ADDRESS_SIZE:0]   read_gray_pointer_i,
    output logic                    write_accept_o,
    output logic [ADDRESS_SIZE-1:0] write_address_o,
    output logic [ADDRESS_SIZE:0]   write_pointer_o,
    output logic                    write_full_o,
    output logic                    write_almost_full_o,
    output logic [ADDRESS_SIZE:0]   write_level_o,
    output logic                    write_overflow_o
);

    localparam int PW    = ADDRESS_SIZE + 1;
    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] rbin;

    logic [PW-1:0] binary_q, binary_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_ff @(posedge write_clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], read_gray_pointer_i};
        end
    end

    // Only the last synchroniser stage is decoded; earlier stages may be metastable.
    assign rbin = gray2bin(sync_q[SYNC_STAGES-1]);

    assign write_accept_o = write_enable_i & ~full_q;

    always_comb begin
        binary_d = binary_q + {{ADDRESS_SIZE{1'b0}}, write_accept_o};
        gray_d   = binary_d ^ (binary_d >> 1);
        level_d  = binary_d - rbin;
        full_d   = (binary_d == {~rbin[PW-1], rbin[PW-2:0]});
        afull_d  = (level_d >= AF_LEVEL);
    end

    always_ff @(posedge write_clock_i or posedge reset_i) begin
        if (reset_i) begin
            binary_q <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

    assign write_address_o     = binary_q[ADDRESS_SIZE-1:0];
    assign write_pointer_o     = gray_q;
    assign write_full_o        = full_q;
    assign write_almost_full_o = afull_q;
    assign write_level_o       = level_q;

`ifdef WRITE_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    // Sticky until reset so software can detect a dropped write after the fact.
    always_comb begin
        overflow_d = overflow_q | (write_enable_i & full_q);
    end

    always_ff @(posedge write_clock_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign write_overflow_o = overflow_q;
`else
    assign write_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_controller.sv
// Scoreboard bench for write_pointer_controller at ADDRESS_SIZE=3, SYNC_STAGES=2, margin 2.
module tb_write_pointer_controller;

    localparam int F_ACC   = 0;
    localparam int F_ADDR  = 1;
    localparam int F_PTR   = 2;
    localparam int F_FULL  = 3;
    localparam int F_AF    = 4;
    localparam int F_LVL   = 5;
    localparam int F_OVF   = 6;
    localparam int F_PSTEP = 7;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset = 1'b0;
    logic       write_enable = 1'b0;
    logic [3:0] read_gray_pointer = 4'd0;
    logic       write_accept;
    logic [2:0] write_address;
    logic [3:0] write_pointer;
    logic       write_full;
    logic       write_almost_full;
    logic [3:0] write_level;
    logic       write_overflow;

    write_pointer_controller #(
        .ADDRESS_SIZE(3),
        .SYNC_STAGES(2),
        .ALMOST_FULL_MARGIN(2)
    ) dut (
        .write_clock_i(clk),
        .reset_i(reset),
        .write_enable_i(write_enable),
        .read_gray_pointer_i(read_gray_pointer),
        .write_accept_o(write_accept),
        .write_address_o(write_address),
        .write_pointer_o(write_pointer),
        .write_full_o(write_full),
        .write_almost_full_o(write_almost_full),
        .write_level_o(write_level),
        .write_overflow_o(write_overflow)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        int         fld;
        logic [7:0] exp;
    } sb_t;

    sb_t sb[$];
    int  ncyc = 0;
    int  next_cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;
    logic [3:0] prev_ptr = 4'd0;

    // Reference state: write count, delayed read binary, registered flags.
    int   m_w = 0;
    int   r_d1 = 0;
    int   r_d2 = 0;
    logic m_full = 1'b0;
    logic m_ovf = 1'b0;

    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic string fname(int f);
        case (f)
            F_ACC:   return "write_accept";
            F_ADDR:  return "write_address";
            F_PTR:   return "write_pointer";
            F_FULL:  return "write_full";
            F_AF:    return "write_almost_full";
            F_LVL:   return "write_level";
            F_OVF:   return "write_overflow";
            default: return "pointer_bits_changed";
        endcase
    endfunction

    function automatic logic [7:0] fval(int f);
        case (f)
            F_ACC:   return {7'd0, write_accept};
            F_ADDR:  return {5'd0, write_address};
            F_PTR:   return {4'd0, write_pointer};
            F_FULL:  return {7'd0, write_full};
            F_AF:    return {7'd0, write_almost_full};
            F_LVL:   return {4'd0, write_level};
            F_OVF:   return {7'd0, write_overflow};
            default: return 8'($countones(write_pointer ^ prev_ptr));
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int cyc, input int fld, input int v);
        sb_t e;
        e.cyc = cyc;
        e.fld = fld;
        e.exp = 8'(v);
        sb.push_back(e);
    endtask

    task automatic expect_c(input int fld, input int v);
        push(next_cyc, fld, v);
    endtask

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // Monitor: samples once per cycle, mid low phase, and retires due expectations.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
                e = sb.pop_front();
                chk(fname(e.fld), fval(e.fld), e.exp);
            end
            prev_ptr = write_pointer;
        end
    end

    task automatic step(input logic we, input logic [3:0] rg, input int rb);
        int   used;
        int   lvl;
        logic acc;
        @(negedge clk);
        write_enable      = we;
        read_gray_pointer = rg;
        used = r_d2;
        r_d2 = r_d1;
        r_d1 = rb % 16;
        acc = we && !m_full;
        push(ncyc, F_ACC, int'(acc));
`ifdef WRITE_OVERFLOW_FLAG_EN
        if (we && m_full) m_ovf = 1'b1;
`endif
        if (acc) m_w = (m_w + 1) % 16;
        lvl    = (m_w - used + 16) % 16;
        m_full = (lvl == 8);
        push(ncyc + 1, F_LVL, lvl);
        push(ncyc + 1, F_FULL, int'(m_full));
        push(ncyc + 1, F_AF, int'(lvl >= 6));
        push(ncyc + 1, F_PTR, int'(to_gray(m_w)));
        push(ncyc + 1, F_ADDR, m_w % 8);
        push(ncyc + 1, F_OVF, int'(m_ovf));
        next_cyc = ncyc + 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_accept"}, {7'd0, write_accept}, 8'd0);
        chk({tag, "_address"}, {5'd0, write_address}, 8'd0);
        chk({tag, "_pointer"}, {4'd0, write_pointer}, 8'd0);
        chk({tag, "_full"}, {7'd0, write_full}, 8'd0);
        chk({tag, "_almost_full"}, {7'd0, write_almost_full}, 8'd0);
        chk({tag, "_level"}, {4'd0, write_level}, 8'd0);
        chk({tag, "_overflow"}, {7'd0, write_overflow}, 8'd0);
    endtask

    task automatic model_clear();
        m_w = 0;
        r_d1 = 0;
        r_d2 = 0;
        m_full = 1'b0;
        m_ovf = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with no clock running.
        #1 reset = 1'b1;
        #1 check_all_zero("reset_noclk");
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();

        // Fill: 8 back-to-back writes against an empty read pointer.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'b0000, 0);
            expect_c(F_LVL, i);
            if (i == 5) expect_c(F_AF, 0);
            if (i == 6) expect_c(F_AF, 1);
        end
        expect_c(F_FULL, 1);
        expect_c(F_PTR, 4'b1100);
        expect_c(F_ADDR, 0);

        // Writes while full are dropped.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0000, 0);
            expect_c(F_LVL, 8);
            expect_c(F_PTR, 4'b1100);
        end
`ifdef WRITE_OVERFLOW_FLAG_EN
        expect_c(F_OVF, 1);
`else
        expect_c(F_OVF, 0);
`endif

        // Read pointer moves to binary 3; full clears exactly three edges later.
        step(1'b0, 4'b0010, 3);
        expect_c(F_FULL, 1);
        step(1'b0, 4'b0010, 3);
        expect_c(F_FULL, 1);
        expect_c(F_LVL, 8);
        step(1'b0, 4'b0010, 3);
        expect_c(F_FULL, 0);
        expect_c(F_LVL, 5);
        expect_c(F_AF, 0);
`ifdef WRITE_OVERFLOW_FLAG_EN
        expect_c(F_OVF, 1);
`endif

        // Wrap: 16 writes, read pointer advancing alongside.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, to_gray(4 + i), 4 + i);
            expect_c(F_PSTEP, 1);
            expect_c(F_FULL, 0);
            if (i == 6) expect_c(F_PTR, 4'b1000);
            if (i == 7) begin
                expect_c(F_PTR, 4'b0000);
                expect_c(F_ADDR, 0);
            end
        end
        step(1'b0, 4'b0010, 3);
        step(1'b0, 4'b0010, 3);
        expect_c(F_LVL, 5);

        // Asynchronous reset in the middle of operation.
        @(negedge clk);
        #3;
        reset = 1'b1;
        write_enable = 1'b0;
        read_gray_pointer = 4'd0;
        #1 check_all_zero("reset_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();

        step(1'b1, 4'b0000, 0);
        expect_c(F_LVL, 1);
        expect_c(F_PTR, 4'b0001);
        step(1'b1, 4'b0000, 0);
        step(1'b0, 4'b0000, 0);
        expect_c(F_LVL, 2);

        repeat (3) @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
